// File: rtl/embedded_system_nios2_qsys_0_div_cell.sv
// ---------------------------------------------------------------------------
// embedded_system_nios2_qsys_0_div_cell
// Iterative radix-2 restoring divider for the Nios II A-stage (div/divu).
// It retires one quotient bit per clock. Signed operands are reduced to
// magnitudes, divided, and then sign-corrected in a final fix-up cycle.
//
// Ports
//   clk                  : single clock, rising edge
//   reset_n              : asynchronous active-low reset
//   A_div_start          : start a divide (sampled only in IDLE)
//   A_div_signed         : 1 = two's-complement divide, 0 = unsigned
//   A_div_src1           : dividend (sampled with start)
//   A_div_src2           : divisor  (sampled with start)
//   A_div_abort          : pipeline flush, cancels CALC/FIXUP
//   A_div_busy           : high from the cycle after start until done retires
//   A_div_done           : one-cycle result-valid pulse
//   A_div_cell_result    : quotient
//   A_div_cell_remainder : remainder (sign follows the dividend)
// ---------------------------------------------------------------------------
module embedded_system_nios2_qsys_0_div_cell #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  A_div_start,
    input  logic                  A_div_signed,
    input  logic [DATA_WIDTH-1:0] A_div_src1,
    input  logic [DATA_WIDTH-1:0] A_div_src2,
    input  logic                  A_div_abort,
    output logic                  A_div_busy,
    output logic                  A_div_done,
    output logic [DATA_WIDTH-1:0] A_div_cell_result,
    output logic [DATA_WIDTH-1:0] A_div_cell_remainder
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] dvd_q;    // dividend shifting out, quotient shifting in
    logic [DATA_WIDTH-1:0] dsr_q;
    logic                  q_neg_q;
    logic                  r_neg_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] remainder_q;

    logic                  src1_neg;
    logic                  src2_neg;
    logic [DATA_WIDTH-1:0] src1_mag;
    logic [DATA_WIDTH-1:0] src2_mag;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH+1:0] trial;
    logic                  trial_ok;
    logic [DATA_WIDTH-1:0] rem_d;
    logic [DATA_WIDTH-1:0] dvd_d;

    // Operand magnitudes for the start cycle
    always_comb begin
        src1_neg = A_div_signed & A_div_src1[DATA_WIDTH-1];
        src2_neg = A_div_signed & A_div_src2[DATA_WIDTH-1];
        src1_mag = src1_neg ? -A_div_src1 : A_div_src1;
        src2_mag = src2_neg ? -A_div_src2 : A_div_src2;
    end

    // One restoring step. The shifted remainder needs DATA_WIDTH+1 bits; the
    // subtraction gets one extra bit so its MSB is a clean borrow/sign flag.
    // The restored remainder is always below the divisor, so it fits back
    // into DATA_WIDTH bits. A zero divisor always succeeds, which yields
    // an all-ones quotient and the dividend as the remainder.
    always_comb begin
        shifted  = {rem_q, dvd_q[DATA_WIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, dsr_q};
        trial_ok = ~trial[DATA_WIDTH+1];
        rem_d    = trial_ok ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
        dvd_d    = {dvd_q[DATA_WIDTH-2:0], trial_ok};
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // start takes priority over a coincident abort
                    if (A_div_start) begin
                        dvd_q   <= src1_mag;
                        dsr_q   <= src2_mag;
                        q_neg_q <= src1_neg ^ src2_neg;
                        r_neg_q <= src1_neg;
                        rem_q   <= '0;
                        cnt_q   <= CNT_W'(DATA_WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (A_div_abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        if (cnt_q == '0) begin
                            state_q <= FIXUP;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                FIXUP: begin
                    if (A_div_abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        result_q    <= q_neg_q ? -dvd_q : dvd_q;
                        remainder_q <= r_neg_q ? -rem_q : rem_q;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign A_div_busy           = busy_q;
    assign A_div_done           = done_q;
    assign A_div_cell_result    = result_q;
    assign A_div_cell_remainder = remainder_q;

endmodule

// File: tb/tb_embedded_system_nios2_qsys_0_div_cell.sv
// ---------------------------------------------------------------------------
// tb_embedded_system_nios2_qsys_0_div_cell
// Directed and small randomized bench for the iterative divider. Expected
// quotient/remainder pairs are queued on each start and compared when done
// pulses; latency, busy, abort, ignored-start and reset behaviour are
// checked inline.
// ---------------------------------------------------------------------------
module tb_embedded_system_nios2_qsys_0_div_cell;

    logic        clk;
    logic        reset_n;
    logic        A_div_start;
    logic        A_div_signed;
    logic [31:0] A_div_src1;
    logic [31:0] A_div_src2;
    logic        A_div_abort;
    logic        A_div_busy;
    logic        A_div_done;
    logic [31:0] A_div_cell_result;
    logic [31:0] A_div_cell_remainder;

    int          n_assert;
    int          n_fail;
    int          done_cnt;
    logic [63:0] sb_q[$];
    logic [31:0] last_q;
    logic [31:0] last_r;

    embedded_system_nios2_qsys_0_div_cell #(
        .DATA_WIDTH(32)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .A_div_start          (A_div_start),
        .A_div_signed         (A_div_signed),
        .A_div_src1           (A_div_src1),
        .A_div_src2           (A_div_src2),
        .A_div_abort          (A_div_abort),
        .A_div_busy           (A_div_busy),
        .A_div_done           (A_div_done),
        .A_div_cell_result    (A_div_cell_result),
        .A_div_cell_remainder (A_div_cell_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: truncating division with the defined divide-by-zero result
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = 32'($signed(a) / $signed(b));
                r = 32'($signed(a) % $signed(b));
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset_n && A_div_done) begin
            done_cnt++;
            n_assert++;
            assert (sb_q.size() != 0)
            else begin
                n_fail++;
                $error("FAIL sb_empty: observed done with no pending expectation, expected none");
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("quotient", A_div_cell_result, e[63:32]);
                check("remainder", A_div_cell_remainder, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one divide, optionally with a coincident abort or a stray start
    // sampled at edge `glitch` (0 = none), then check latency and busy.
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input bit with_abort, input int glitch);
        int edges;
        bit busy_ok;
        int d0;
        d0           = done_cnt;
        A_div_signed = s;
        A_div_src1   = a;
        A_div_src2   = b;
        A_div_start  = 1'b1;
        A_div_abort  = with_abort;
        sb_q.push_back({eq, er});
        step();
        A_div_start = 1'b0;
        A_div_abort = 1'b0;
        edges       = 1;
        busy_ok     = 1'b1;
        while (!A_div_done && edges < 100) begin
            if (!A_div_busy) busy_ok = 1'b0;
            if (glitch != 0 && edges == glitch - 1) begin
                A_div_start  = 1'b1;
                A_div_signed = ~s;
                A_div_src1   = ~a;
                A_div_src2   = 32'd3;
            end
            step();
            A_div_start = 1'b0;
            edges++;
        end
        check("latency", 32'(edges), 32'd34);
        check("busy_while_calc", 32'(busy_ok), 32'd1);
        check("busy_at_done", 32'(A_div_busy), 32'd1);
        step();
        check("done_one_cycle", 32'(A_div_done), 32'd0);
        check("busy_after_done", 32'(A_div_busy), 32'd0);
        check("done_count", 32'(done_cnt - d0), 32'd1);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        logic [63:0] m;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        int          d0;

        n_assert     = 0;
        n_fail       = 0;
        done_cnt     = 0;
        reset_n      = 1'b0;
        A_div_start  = 1'b0;
        A_div_signed = 1'b0;
        A_div_src1   = '0;
        A_div_src2   = '0;
        A_div_abort  = 1'b0;
        last_q       = '0;
        last_r       = '0;

        #3;
        check("rst_busy", 32'(A_div_busy), 32'd0);
        check("rst_done", 32'(A_div_done), 32'd0);
        check("rst_result", A_div_cell_result, 32'd0);
        check("rst_remainder", A_div_cell_remainder, 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        step();

        // Basic unsigned and signed cases
        run_div(1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 1'b0, 0);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 0);
        run_div(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002, 1'b0, 0);

        // Divide by zero and signed overflow
        run_div(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 0);
        run_div(1'b1, 32'h8000_0000, 32'd0, 32'h0000_0001, 32'h8000_0000, 1'b0, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 0);

        // Start with a coincident abort in IDLE: start wins
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);

        // Stray start at cycle 10 of an active divide is ignored
        run_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 10);

        // Abort mid-CALC: no done, busy drops, outputs hold
        d0           = done_cnt;
        A_div_signed = 1'b0;
        A_div_src1   = 32'hDEAD_BEEF;
        A_div_src2   = 32'h0000_0010;
        A_div_start  = 1'b1;
        step();
        A_div_start = 1'b0;
        repeat (13) step();
        A_div_abort = 1'b1;
        step();
        A_div_abort = 1'b0;
        check("abort_busy", 32'(A_div_busy), 32'd0);
        check("abort_done", 32'(A_div_done), 32'd0);
        check("abort_hold_q", A_div_cell_result, last_q);
        check("abort_hold_r", A_div_cell_remainder, last_r);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_div(1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 0);

        // A few randomized operands against the model
        for (int i = 0; i < 4; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom();
            rb = (i == 3) ? 32'($urandom_range(1, 255)) : $urandom();
            m  = model(rs, ra, rb);
            run_div(rs, ra, rb, m[63:32], m[31:0], 1'b0, 0);
        end

        // Asynchronous reset mid-divide
        A_div_signed = 1'b0;
        A_div_src1   = 32'h1234_5678;
        A_div_src2   = 32'd3;
        A_div_start  = 1'b1;
        step();
        A_div_start = 1'b0;
        repeat (18) step();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(A_div_busy), 32'd0);
        check("arst_done", 32'(A_div_done), 32'd0);
        check("arst_result", A_div_cell_result, 32'd0);
        check("arst_remainder", A_div_cell_remainder, 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        run_div(1'b0, 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 0);

        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
